div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle unsigned integer divider. It is the initiator and consumer of the existing rcp reciprocal unit.
- Computes q = floor(n/d) and rem = n mod d, exact. Method: fetch ~2^width/d from rcp, multiply by n, then correct the estimate one step per cycle.
- Sits between the shader ALU issue stage and writeback, with a valid/ready handshake on both sides.

Parameters:
- width, 16, operand/result width in bits.
- iters, 3, Newton iterations forwarded to the internal rcp instance.
- fix_max, 7, maximum correction steps permitted. Used by assertions only; does not change the datapath.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- v_i  input  1  request valid.
- rdy_o  output  1  request accepted when v_i && rdy_o.
- n_i  input  width  numerator.
- d_i  input  width  denominator.
- v_o  output  1  result valid.
- rdy_i  input  1  downstream ready; result retires on v_o && rdy_i.
- q_o  output  width  quotient.
- rem_o  output  width  remainder.
- dz_o  output  1  divide-by-zero flag, qualified by v_o.

Behaviour:
- Reset (async assert, deasserted synchronous to clk_i): state=IDLE, rdy_o=1, v_o=0, q_o=0, rem_o=0, dz_o=0. Any in-flight operation is discarded and no result is produced.
- Single operation in flight. rdy_o=1 only in IDLE.
- IDLE: on v_i, latch n_i/d_i.
  - d_i==0: go to DONE with q=all-ones, rem=n, dz=1.
  - d_i==1: go to DONE with q=n, rem=0.
  - Otherwise: drive rcp v_i=1, a_i=d_i this cycle; next state RCP.
- RCP: rcp has 1-cycle latency; its ready_o is its output-valid. Its result r is treated as an unsigned approximation of 2^width/d. Next state MUL.
- MUL: p = n*r (2*width bits); q_est = p[2*width-1:width]; rem_s = n - q_est*d, computed signed in width+2 bits. Next state FIX.
- FIX: one correction per cycle.
  - rem_s<0: q--, rem_s+=d.
  - rem_s>=d: q++, rem_s-=d.
  - Otherwise go to DONE.
  - Step count must be <=fix_max (assertion). q must never wrap below 0 or above all-ones (assertion).
- DONE: v_o=1; q_o/rem_o/dz_o held stable while v_o && !rdy_i. On rdy_i go to IDLE, v_o=0 next cycle.
- No new request may be accepted in the same cycle a result retires; rdy_o rises the cycle after retirement.
- Latency, accept edge to v_o: d in {0,1} = 1 cycle; else 3 + k cycles, where k = number of correction steps.
- Outputs are registered only; no combinational path from v_i/rdy_i to v_o/rdy_o.
- rem_o < d whenever dz_o=0 (assertion).

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, RCP, MUL, FIX, DONE}.
  - localparam for the rem_s width (width+2).
- Sub-module: the existing rcp, instantiated once.
- The correction step may be a small combinational function in div_pkg. No other sub-modules.

Test Plan:
- n=100, d=7, rdy_i=1 -> v_o once, q_o=14, rem_o=2, dz_o=0. rdy_o low from accept until the cycle after retirement.
- n=0xFFFF, d=1 -> v_o exactly 1 cycle after accept, q_o=0xFFFF, rem_o=0. Also n=0xFFFF, d=0xFFFF -> q_o=1, rem_o=0.
- n=0x1234, d=0 -> v_o after 1 cycle, dz_o=1, q_o=0xFFFF, rem_o=0x1234.
- n=5, d=9 -> q_o=0, rem_o=5, no negative-wrap assertion.
- Back-pressure: n=1000, d=3, hold rdy_i=0 for 5 cycles after v_o -> q_o=333, rem_o=1 stable all 5 cycles, v_i ignored while rdy_o=0.
- Reset: assert rst_ni=0 in FIX mid-operation -> outputs return to reset values immediately. After release, request n=50, d=6 -> q_o=8, rem_o=2 with no stale result emitted. Then 10k random (n, d) pairs checked against a reference model, with correction count <= fix_max.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the div_unit datapath.
//   state_e   : controller states of the divider FSM.
//   rem_width : width of the signed remainder. It has two bits more than the
//               operands so the estimate can go below zero or reach 2*d
//               without wrapping.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RCP,
    MUL,
    FIX,
    DONE
  } state_e;

  localparam int unsigned REM_GUARD = 2;

  function automatic int unsigned rem_width(input int unsigned w);
    return w + REM_GUARD;
  endfunction

endpackage

// File: rtl/rcp.sv
// Reciprocal unit: r_o ~= floor(2^width / a_i), one cycle after v_i.
// The operand is normalised to m in [0.5, 1). A linear seed
// 48/17 - 32/17*m is refined by `iters` Newton steps x <- x*(2 - m*x), and
// the result is shifted back. Newton on 1/m approaches from below, so r_o
// never exceeds the true reciprocal and is at most a couple of LSBs under it.
// For a_i == 1 the true result 2^width does not fit, and a_i == 0 has no
// meaningful result. Callers must handle both operands themselves.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   v_i     : request valid, a_i sampled on this edge
//   a_i     : divisor to invert
//   ready_o : r_o valid (one cycle after v_i)
//   r_o     : reciprocal estimate
module rcp #(
  parameter int unsigned width = 16,
  parameter int unsigned iters = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             v_i,
  input  logic [width-1:0] a_i,
  output logic             ready_o,
  output logic [width-1:0] r_o
);

  localparam int unsigned FB = 2 * width;      // fraction bits of m and x
  localparam int unsigned PW = 2 * FB + 12;    // room for every product
  localparam int unsigned SW = $clog2(width);

  localparam logic [PW-1:0] TWO = PW'(2) << FB;
  localparam logic [PW-1:0] C48 = (PW'(48) << FB) / PW'(17);
  localparam logic [PW-1:0] C32 = (PW'(32) << FB) / PW'(17);

  logic [SW-1:0]    msb;
  logic [width-1:0] a_nrm;
  logic [PW-1:0]    m;
  logic [PW-1:0]    x;
  logic [PW-1:0]    t;
  logic [width-1:0] r_nxt;
  logic             ready_q;
  logic [width-1:0] r_q;

  // NOTE: every variable gets a value before any branch or loop, so no latch is inferred.
  always_comb begin
    msb = '0;
    for (int i = 0; i < width; i++) begin
      if (a_i[i]) msb = SW'(i);
    end
    a_nrm = a_i << (SW'(width - 1) - msb);
    m     = PW'(a_nrm) << width;
    x     = C48 - ((C32 * m) >> FB);
    t     = '0;
    for (int k = 0; k < iters; k++) begin
      t = (m * x) >> FB;
      x = (x * (TWO - t)) >> FB;
    end
    // x ~ 2^FB / m and 2^width / a = (1/m) * 2^(width-1-msb)
    r_nxt = width'(x >> (FB - width + 1 + int'(msb)));
  end

  // NOTE: registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ready_q <= 1'b0;
    else         ready_q <= v_i;
  end

  // NOTE: datapath register without reset. It is only consumed while ready_q is high.
  always_ff @(posedge clk_i) begin
    if (v_i) r_q <= r_nxt;
  end

  assign ready_o = ready_q;
  assign r_o     = r_q;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle unsigned divider: q = floor(n/d), rem = n mod d, exact.
// The unit gets ~2^width/d from rcp, multiplies it by n to estimate q, and
// then corrects the estimate by one unit per cycle until 0 <= rem < d.
// The divisors 0 and 1 take a one-cycle path that bypasses rcp.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   v_i / rdy_o   : request handshake, n_i / d_i sampled on v_i && rdy_o
//   v_o / rdy_i   : result handshake, result retires on v_o && rdy_i
//   q_o, rem_o    : quotient and remainder, held while v_o && !rdy_i
//   dz_o          : divide-by-zero (q_o = all ones, rem_o = n)
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned width   = 16,
  parameter int unsigned iters   = 3,
  parameter int unsigned fix_max = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             v_i,
  output logic             rdy_o,
  input  logic [width-1:0] n_i,
  input  logic [width-1:0] d_i,
  output logic             v_o,
  input  logic             rdy_i,
  output logic [width-1:0] q_o,
  output logic [width-1:0] rem_o,
  output logic             dz_o
);

  localparam int unsigned      RW  = rem_width(width);
  localparam int unsigned      CW  = $clog2(fix_max + 2);
  localparam logic [width-1:0] ONE = width'(1);

  state_e               state_q, state_d;
  logic [width-1:0]     n_q, n_d, d_q, d_d, r_q, r_d;
  logic [width-1:0]     q_q, q_d;
  logic signed [RW-1:0] rem_q, rem_d;
  logic                 dz_q, dz_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 rcp_v, rcp_rdy;
  logic [width-1:0]     rcp_r;

  rcp #(
    .width(width),
    .iters(iters)
  ) u_rcp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .v_i    (rcp_v),
    .a_i    (d_i),
    .ready_o(rcp_rdy),
    .r_o    (rcp_r)
  );

  // The estimate: q_est = (n * r) >> width, rem_est = n - q_est * d.
  logic [2*width-1:0]   prod_nr, prod_qd;
  logic [width-1:0]     q_est;
  logic signed [RW-1:0] rem_est, d_s;

  assign prod_nr = (2*width)'(n_q) * (2*width)'(r_q);
  assign q_est   = width'(prod_nr >> width);
  assign prod_qd = (2*width)'(q_est) * (2*width)'(d_q);
  assign d_s     = $signed(RW'(d_q));
  assign rem_est = $signed(RW'(n_q)) - $signed(RW'(prod_qd));

  function automatic logic in_range(input logic signed [RW-1:0] rs,
                                    input logic signed [RW-1:0] dv);
    return !rs[RW-1] && (rs < dv);
  endfunction

  // One correction step. FIX is only entered when out of range, so a
  // non-negative remainder here means rem >= d.
  logic [width-1:0]     q_fix;
  logic signed [RW-1:0] rem_fix;

  always_comb begin
    if (rem_q[RW-1]) begin
      q_fix   = q_q - ONE;
      rem_fix = rem_q + d_s;
    end else begin
      q_fix   = q_q + ONE;
      rem_fix = rem_q - d_s;
    end
  end

  // The range check looks ahead, so k corrections cost exactly k FIX cycles.
  // An exact estimate goes from MUL straight to DONE.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    rcp_v   = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          n_d   = n_i;
          d_d   = d_i;
          dz_d  = 1'b0;
          cnt_d = '0;
          if (d_i == '0) begin
            q_d     = '1;
            rem_d   = RW'(n_i);
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (d_i == ONE) begin
            q_d     = n_i;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rcp_v   = 1'b1;
            state_d = RCP;
          end
        end
      end
      RCP: begin
        if (rcp_rdy) begin
          r_d     = rcp_r;
          state_d = MUL;
        end
      end
      MUL: begin
        q_d     = q_est;
        rem_d   = rem_est;
        state_d = in_range(rem_est, d_s) ? DONE : FIX;
      end
      FIX: begin
        q_d     = q_fix;
        rem_d   = rem_fix;
        cnt_d   = cnt_q + CW'(1);
        state_d = in_range(rem_fix, d_s) ? DONE : FIX;
      end
      DONE: begin
        if (rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    n_q <= n_d;
    d_q <= d_d;
    r_q <= r_d;
  end

  // All outputs decode registers only.
  assign rdy_o = (state_q == IDLE);
  assign v_o   = (state_q == DONE);
  assign q_o   = q_q;
  assign rem_o = rem_q[width-1:0];
  assign dz_o  = dz_q;

  a_fix_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q <= CW'(fix_max)));
  a_q_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == FIX && rem_q[RW-1]) |-> (q_q != '0));
  a_q_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == FIX && !rem_q[RW-1]) |-> (q_q != '1));
  a_rem_lt_d: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == DONE && !dz_q) |-> (!rem_q[RW-1] && rem_q < d_s));
  a_rcp_latency: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == RCP) |-> rcp_rdy);

endmodule
